// File: rtl/quad_velocity.sv
// Per-period velocity from a modular 32-bit position count, with a boxcar
// average over the last 2^AVG_LOG deltas and a zero-motion stall flag.
module quad_velocity #(
  parameter int PERIOD  = 50000,
  parameter int VEL_W   = 16,
  parameter int AVG_LOG = 2,
  parameter int STALL_N = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [31:0]             count,
  input  logic                    enable,
  output logic signed [VEL_W-1:0] velocity,
  output logic signed [VEL_W-1:0] velocity_avg,
  output logic                    valid,
  output logic                    saturated,
  output logic                    stalled
);

  localparam int DEPTH = 1 << AVG_LOG;
  localparam int PW    = (AVG_LOG > 0) ? AVG_LOG : 1;
  localparam int PS_W  = $clog2(PERIOD);
  localparam int SUM_W = VEL_W + AVG_LOG;
  localparam int ST_W  = $clog2(STALL_N + 1);
  localparam logic signed [63:0] VMAX = (64'sd1 <<< (VEL_W - 1)) - 64'sd1;
  localparam logic signed [63:0] VMIN = -(64'sd1 <<< (VEL_W - 1));

  logic [PS_W-1:0]         r_presc;
  logic [31:0]             r_count_prev;
  logic                    r_prime;
  logic signed [VEL_W-1:0] r_ring [DEPTH];
  logic [PW-1:0]           r_ptr;
  logic signed [SUM_W-1:0] r_sum;
  logic [ST_W-1:0]         r_stall_cnt;
  logic signed [VEL_W-1:0] r_velocity;
  logic signed [VEL_W-1:0] r_velocity_avg;
  logic                    r_valid;
  logic                    r_saturated;
  logic                    r_stalled;

  logic                    w_tick;
  logic                    w_prime;
  logic                    w_normal;
  logic [31:0]             w_delta32;
  logic signed [63:0]      w_delta64;
  logic signed [VEL_W-1:0] w_sat_val;
  logic                    w_clip;
  logic signed [VEL_W-1:0] w_oldest;
  logic signed [SUM_W-1:0] w_sum_next;
  logic signed [VEL_W-1:0] w_avg;
  logic [PW-1:0]           w_ptr_next;
  logic [ST_W-1:0]         w_stall_next;

  assign w_tick   = enable && (r_presc == PS_W'(PERIOD - 1));
  assign w_prime  = w_tick && r_prime;
  assign w_normal = w_tick && !r_prime;

  // Modular subtraction read as signed gives the right answer across the 0/0xFFFFFFFF seam.
  assign w_delta32 = count - r_count_prev;
  assign w_delta64 = {{32{w_delta32[31]}}, w_delta32};

  always_comb begin
    w_sat_val = VEL_W'(w_delta64);
    w_clip    = 1'b0;
    if (w_delta64 > VMAX) begin
      w_sat_val = VEL_W'(VMAX);
      w_clip    = 1'b1;
    end else if (w_delta64 < VMIN) begin
      w_sat_val = VEL_W'(VMIN);
      w_clip    = 1'b1;
    end
  end

  assign w_oldest   = r_ring[r_ptr];
  assign w_sum_next = r_sum - SUM_W'(w_oldest) + SUM_W'(w_sat_val);
  assign w_avg      = VEL_W'(w_sum_next >>> AVG_LOG);
  assign w_ptr_next = (r_ptr == PW'(DEPTH - 1)) ? '0 : r_ptr + PW'(1);

  always_comb begin
    w_stall_next = '0;
    if (w_sat_val == '0)
      w_stall_next = (r_stall_cnt == ST_W'(STALL_N)) ? r_stall_cnt : r_stall_cnt + ST_W'(1);
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_ring
      always_ff @(posedge clk) begin
        if (reset || w_prime)
          r_ring[gi] <= '0;
        else if (w_normal && (r_ptr == PW'(gi)))
          r_ring[gi] <= w_sat_val;
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_presc        <= '0;
      r_count_prev   <= '0;
      r_prime        <= 1'b1;
      r_ptr          <= '0;
      r_sum          <= '0;
      r_stall_cnt    <= '0;
      r_velocity     <= '0;
      r_velocity_avg <= '0;
      r_valid        <= 1'b0;
      r_saturated    <= 1'b0;
      r_stalled      <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (!enable) begin
        r_presc <= '0;
        r_prime <= 1'b1;
      end else begin
        r_presc <= w_tick ? '0 : r_presc + PS_W'(1);
      end
      if (w_prime) begin
        r_count_prev <= count;
        r_prime      <= 1'b0;
        r_ptr        <= '0;
        r_sum        <= '0;
        r_stall_cnt  <= '0;
      end else if (w_normal) begin
        r_count_prev   <= count;
        r_ptr          <= w_ptr_next;
        r_sum          <= w_sum_next;
        r_stall_cnt    <= w_stall_next;
        r_velocity     <= w_sat_val;
        r_velocity_avg <= w_avg;
        r_saturated    <= w_clip;
        r_stalled      <= (w_stall_next == ST_W'(STALL_N));
        r_valid        <= 1'b1;
      end
    end
  end

  assign velocity     = r_velocity;
  assign velocity_avg = r_velocity_avg;
  assign valid        = r_valid;
  assign saturated    = r_saturated;
  assign stalled      = r_stalled;

endmodule

// File: tb/tb_quad_velocity.sv
// Directed bench for quad_velocity: PERIOD=10, VEL_W=16, AVG_LOG=2, STALL_N=8.
module tb_quad_velocity;
  logic               clk = 1'b0;
  logic               reset;
  logic [31:0]        count;
  logic               enable;
  logic signed [15:0] velocity;
  logic signed [15:0] velocity_avg;
  logic               valid;
  logic               saturated;
  logic               stalled;

  int total = 0;
  int bad   = 0;

  quad_velocity #(.PERIOD(10), .VEL_W(16), .AVG_LOG(2), .STALL_N(8)) dut (
    .clk(clk), .reset(reset), .count(count), .enable(enable),
    .velocity(velocity), .velocity_avg(velocity_avg), .valid(valid),
    .saturated(saturated), .stalled(stalled)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int limit, output int n, output bit got);
    n   = 0;
    got = 1'b0;
    while (n < limit && !got) begin
      step();
      n++;
      if (valid === 1'b1) got = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; count = 32'd0;
    repeat (3) step();
    reset = 1'b0;
    step();
    total++; if (velocity !== 16'sd0) begin bad++; $display("FAIL reset_vel got=%0d exp=0", velocity); end
    total++; if (velocity_avg !== 16'sd0) begin bad++; $display("FAIL reset_avg got=%0d exp=0", velocity_avg); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", valid); end
    total++; if (saturated !== 1'b0) begin bad++; $display("FAIL reset_sat got=%b exp=0", saturated); end
    total++; if (stalled !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stalled); end
    $display("test_reset: outputs checked after reset");
  endtask

  task automatic test_constant_speed();
    int n; bit got; bit early;
    logic signed [15:0] exp_avg [4] = '{16'sd15, 16'sd22, 16'sd30, 16'sd30};
    count = 32'd100; enable = 1'b1;
    early = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (valid !== 1'b0) early = 1'b1;
    end
    total++; if (early) begin bad++; $display("FAIL prime_no_valid got=1 exp=0"); end
    count = count + 32'd30;
    wait_valid(30, n, got);
    total++; if (!got || n != 10) begin bad++; $display("FAIL first_valid_latency got=%0d exp=10", n); end
    total++; if (velocity !== 16'sd30) begin bad++; $display("FAIL cs_vel0 got=%0d exp=30", velocity); end
    total++; if (velocity_avg !== 16'sd7) begin bad++; $display("FAIL cs_avg0 got=%0d exp=7", velocity_avg); end
    $display("const: n=%0d vel=%0d avg=%0d", n, velocity, velocity_avg);
    step();
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL valid_width got=%b exp=0", valid); end
    for (int i = 0; i < 4; i++) begin
      count = count + 32'd30;
      wait_valid(30, n, got);
      total++; if (!got || n != (i == 0 ? 9 : 10)) begin bad++; $display("FAIL cs_spacing%0d got=%0d exp=%0d", i, n, (i == 0 ? 9 : 10)); end
      total++; if (velocity !== 16'sd30) begin bad++; $display("FAIL cs_vel%0d got=%0d exp=30", i + 1, velocity); end
      total++; if (velocity_avg !== exp_avg[i]) begin bad++; $display("FAIL cs_avg%0d got=%0d exp=%0d", i + 1, velocity_avg, exp_avg[i]); end
      $display("const: n=%0d vel=%0d avg=%0d", n, velocity, velocity_avg);
    end
  endtask

  task automatic test_stall();
    int n; bit got;
    for (int i = 1; i <= 9; i++) begin
      wait_valid(30, n, got);
      total++; if (!got || velocity !== 16'sd0) begin bad++; $display("FAIL stall_vel%0d got=%0d exp=0", i, velocity); end
      total++; if (stalled !== (i >= 8)) begin bad++; $display("FAIL stall_flag%0d got=%b exp=%b", i, stalled, (i >= 8)); end
      $display("stall: sample %0d stalled=%b", i, stalled);
    end
    count = count + 32'd5;
    wait_valid(30, n, got);
    total++; if (!got || velocity !== 16'sd5) begin bad++; $display("FAIL stall_move_vel got=%0d exp=5", velocity); end
    total++; if (stalled !== 1'b0) begin bad++; $display("FAIL stall_clear got=%b exp=0", stalled); end
    $display("stall: motion vel=%0d stalled=%b", velocity, stalled);
  endtask

  task automatic test_wrap();
    int n; bit got;
    count = 32'hFFFF_FFFE;
    wait_valid(30, n, got);
    count = 32'h0000_0003;
    wait_valid(30, n, got);
    total++; if (!got || velocity !== 16'sd5) begin bad++; $display("FAIL wrap_fwd got=%0d exp=5", velocity); end
    $display("wrap: fwd vel=%0d", velocity);
    count = 32'hFFFF_FFFE;
    wait_valid(30, n, got);
    total++; if (!got || velocity !== -16'sd5) begin bad++; $display("FAIL wrap_rev got=%0d exp=-5", velocity); end
    $display("wrap: rev vel=%0d", velocity);
  endtask

  task automatic test_saturation();
    int n; bit got;
    count = count + 32'd40000;
    wait_valid(30, n, got);
    total++; if (!got || velocity !== 16'sd32767) begin bad++; $display("FAIL sat_pos_vel got=%0d exp=32767", velocity); end
    total++; if (saturated !== 1'b1) begin bad++; $display("FAIL sat_pos_flag got=%b exp=1", saturated); end
    $display("sat: vel=%0d sat=%b", velocity, saturated);
    count = count - 32'd40000;
    wait_valid(30, n, got);
    total++; if (!got || velocity !== -16'sd32768) begin bad++; $display("FAIL sat_neg_vel got=%0d exp=-32768", velocity); end
    total++; if (saturated !== 1'b1) begin bad++; $display("FAIL sat_neg_flag got=%b exp=1", saturated); end
    $display("sat: vel=%0d sat=%b", velocity, saturated);
    count = count + 32'd100;
    wait_valid(30, n, got);
    total++; if (!got || velocity !== 16'sd100) begin bad++; $display("FAIL sat_off_vel got=%0d exp=100", velocity); end
    total++; if (saturated !== 1'b0) begin bad++; $display("FAIL sat_off_flag got=%b exp=0", saturated); end
    $display("sat: vel=%0d sat=%b", velocity, saturated);
  endtask

  task automatic test_enable_toggle();
    int n; bit got; bit spurious;
    repeat (3) step();
    enable = 1'b0;
    count = count + 32'd1000;
    spurious = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (valid !== 1'b0) spurious = 1'b1;
    end
    total++; if (velocity !== 16'sd100) begin bad++; $display("FAIL en_hold_vel got=%0d exp=100", velocity); end
    enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (valid !== 1'b0) spurious = 1'b1;
    end
    total++; if (spurious) begin bad++; $display("FAIL en_no_valid got=1 exp=0"); end
    count = count + 32'd7;
    wait_valid(30, n, got);
    total++; if (!got || n != 10) begin bad++; $display("FAIL en_latency got=%0d exp=10", n); end
    total++; if (velocity !== 16'sd7) begin bad++; $display("FAIL en_vel got=%0d exp=7", velocity); end
    total++; if (velocity_avg !== 16'sd1) begin bad++; $display("FAIL en_avg got=%0d exp=1", velocity_avg); end
    $display("enable: n=%0d vel=%0d avg=%0d", n, velocity, velocity_avg);
  endtask

  task automatic test_reset_mid_run();
    int n; bit got;
    repeat (9) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", valid); end
    total++; if (velocity !== 16'sd0) begin bad++; $display("FAIL rst_vel got=%0d exp=0", velocity); end
    total++; if (velocity_avg !== 16'sd0) begin bad++; $display("FAIL rst_avg got=%0d exp=0", velocity_avg); end
    total++; if (saturated !== 1'b0 || stalled !== 1'b0) begin bad++; $display("FAIL rst_flags got=%b%b exp=00", saturated, stalled); end
    wait_valid(40, n, got);
    total++; if (!got || n != 20) begin bad++; $display("FAIL rst_latency got=%0d exp=20", n); end
    total++; if (velocity !== 16'sd0) begin bad++; $display("FAIL rst_post_vel got=%0d exp=0", velocity); end
    $display("reset mid-run: n=%0d vel=%0d", n, velocity);
  endtask

  initial begin
    test_reset();
    test_constant_speed();
    test_stall();
    test_wrap();
    test_saturation();
    test_enable_toggle();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
